dci_lvds_cal_ctrl: RTL and testbench

Impedance-calibration sequencer for the DCI-terminated LVDS input buffers of one I/O bank. It runs a successive-approximation (SAR) search on a shared termination code, using a reference-resistor comparator, then holds the locked code for every differential input buffer in the bank. It sits between the bank's reference comparator and the buffers' termination-code inputs, and runs once per START request.

---
 rtl/dci_lvds_cal_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dci_lvds_cal_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dci_lvds_cal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dci_lvds_cal_ctrl                                               |
// | Brief    : SAR impedance-calibration sequencer for a bank of DCI LVDS      |
// |            inputs. Define DCI_CAL_TRACK_EN to enable tracking in LOCK.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module dci_lvds_cal_ctrl #(
    parameter int CODE_W       = 5,
    parameter int SETTLE_CYC   = 8,
    parameter int RECAL_PERIOD = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              freeze,
    input  logic              cmp_hi,
    output logic [CODE_W-1:0] code,
    output logic              code_vld,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MID    = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              start_q;
    logic [CODE_W-1:0] bit_mask;
    logic [CODE_W-1:0] sample_code;
    logic [CODE_W-1:0] trial_next;

`ifdef DCI_CAL_TRACK_EN
    localparam int TRK_W = (RECAL_PERIOD > 1) ? $clog2(RECAL_PERIOD) : 1;
    localparam logic [TRK_W-1:0] TRK_LOAD = TRK_W'(RECAL_PERIOD - 1);

    logic [TRK_W-1:0]  trk_cnt;
    logic              trk_prev;
    logic              trk_have;
`endif

    // The trial bit is kept when the comparator says the code is still too weak.
    assign bit_mask    = CODE_W'(1) << bit_idx;
    assign sample_code = cmp_hi ? code : (code & ~bit_mask);
    assign trial_next  = sample_code | (bit_mask >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_q) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                if (!freeze && settle_cnt == '0) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!freeze) state_nxt = (bit_idx == '0) ? ST_LOCK : ST_APPLY;
            end
            ST_LOCK: begin
                if (start_q) state_nxt = ST_APPLY;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_APPLY) || (state == ST_SAMPLE);
        code_vld = (state == ST_LOCK);
    end

    // START is registered once, so the first trial appears one edge after it is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code       <= CODE_MID;
            err        <= 1'b0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            start_q    <= 1'b0;
`ifdef DCI_CAL_TRACK_EN
            trk_cnt    <= '0;
            trk_prev   <= 1'b0;
            trk_have   <= 1'b0;
`endif
        end else begin
            start_q <= start && !busy;
            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        bit_idx    <= IDX_TOP;
                        code       <= CODE_MID;
                        settle_cnt <= SETTLE_LOAD;
                        err        <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (!freeze && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    if (!freeze) begin
                        if (bit_idx != '0) begin
                            code       <= trial_next;
                            bit_idx    <= bit_idx - 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            code <= sample_code;
                            err  <= (sample_code == '0) ||
                                    (sample_code == CODE_MAX && cmp_hi);
`ifdef DCI_CAL_TRACK_EN
                            trk_cnt  <= TRK_LOAD;
                            trk_have <= 1'b0;
`endif
                        end
                    end
                end
                ST_LOCK: begin
                    if (start_q) begin
                        bit_idx    <= IDX_TOP;
                        code       <= CODE_MID;
                        settle_cnt <= SETTLE_LOAD;
                        err        <= 1'b0;
                    end
`ifdef DCI_CAL_TRACK_EN
                    else if (!freeze) begin
                        if (trk_cnt == '0) begin
                            trk_cnt  <= TRK_LOAD;
                            trk_prev <= cmp_hi;
                            trk_have <= 1'b1;
                            // Two agreeing samples in a row are needed before a step.
                            if (trk_have && trk_prev == cmp_hi) begin
                                if (cmp_hi) begin
                                    if (code == CODE_MAX) err <= 1'b1;
                                    else                  code <= code + 1'b1;
                                end else begin
                                    if (code == '0) err <= 1'b1;
                                    else            code <= code - 1'b1;
                                end
                            end
                        end else begin
                            trk_cnt <= trk_cnt - 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dci_lvds_cal_ctrl.sv
`default_nettype none
// Directed bench for dci_lvds_cal_ctrl (CODE_W=5, SETTLE_CYC=4, tracking not compiled in).
module tb_dci_lvds_cal_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       freeze;
    logic       cmp_hi;
    logic [4:0] code;
    logic       code_vld;
    logic       busy;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;
    int thr        = 19;
    int tie        = -1;

    always #5 clk = ~clk;

    always_comb begin
        cmp_hi = 1'b0;
        if (tie == 1)      cmp_hi = 1'b1;
        else if (tie == 0) cmp_hi = 1'b0;
        else               cmp_hi = (int'(code) < thr);
    end

    dci_lvds_cal_ctrl #(
        .CODE_W       (5),
        .SETTLE_CYC   (4),
        .RECAL_PERIOD (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .freeze   (freeze),
        .cmp_hi   (cmp_hi),
        .code     (code),
        .code_vld (code_vld),
        .busy     (busy),
        .err      (err)
    );

    // Leaves the bench 1 time unit after edge 0 (the edge that samples START).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; freeze = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (code !== 5'd16) begin miscompares++; $display("FAIL reset_code: got %0d expected 16", code); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (code_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b expected 0", code_vld); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal();
        int exp_tr[5] = '{16, 24, 20, 18, 19};
        tie = -1; thr = 19;
        pulse_start();
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk); #1;
            if (e <= 25 && ((e - 1) % 5) == 0) begin
                vectors++;
                if (code !== 5'(exp_tr[(e - 1) / 5])) begin
                    miscompares++; $display("FAIL trial_code@%0d: got %0d expected %0d", e, code, exp_tr[(e - 1) / 5]);
                end
            end
            if (e == 1) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_rise: got %b expected 1", busy); end
            end
            if (e == 25) begin
                vectors++; if (code_vld !== 1'b0 || busy !== 1'b1) begin
                    miscompares++; $display("FAIL early_lock: got vld=%b busy=%b expected vld=0 busy=1", code_vld, busy);
                end
            end
        end
        vectors++; if (code !== 5'd18) begin miscompares++; $display("FAIL nominal_code: got %0d expected 18", code); end
        vectors++; if (code_vld !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL nominal_flags: got vld=%b busy=%b expected vld=1 busy=0", code_vld, busy);
        end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL nominal_err: got %b expected 0", err); end
    endtask

    task automatic test_saturation();
        for (int t = 1; t >= 0; t--) begin
            tie = t;
            pulse_start();
            repeat (25) @(posedge clk);
            #1;
            vectors++; if (code_vld !== 1'b0) begin miscompares++; $display("FAIL sat%0d_early: got vld=%b expected 0", t, code_vld); end
            @(posedge clk); #1;
            vectors++; if (code !== ((t == 1) ? 5'd31 : 5'd0)) begin
                miscompares++; $display("FAIL sat%0d_code: got %0d expected %0d", t, code, (t == 1) ? 31 : 0);
            end
            vectors++; if (err !== 1'b1 || code_vld !== 1'b1) begin
                miscompares++; $display("FAIL sat%0d_flags: got err=%b vld=%b expected err=1 vld=1", t, err, code_vld);
            end
        end
        tie = -1;
    endtask

    task automatic test_freeze();
        tie = -1; thr = 19;
        pulse_start();
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk); #1;
            if (e == 12) freeze = 1'b1;
            if (e == 19) begin
                freeze = 1'b0;
                vectors++; if (code !== 5'd20) begin miscompares++; $display("FAIL freeze_hold: got %0d expected 20", code); end
            end
            if (e == 22) start = 1'b1;
            if (e == 23) begin
                start = 1'b0;
                vectors++; if (code !== 5'd18) begin miscompares++; $display("FAIL freeze_trial4: got %0d expected 18", code); end
            end
            if (e == 32) begin
                vectors++; if (code_vld !== 1'b0) begin miscompares++; $display("FAIL freeze_early: got vld=%b expected 0", code_vld); end
            end
            if (e == 33) begin
                vectors++; if (code_vld !== 1'b1 || code !== 5'd18) begin
                    miscompares++; $display("FAIL freeze_lock: got vld=%b code=%0d expected vld=1 code=18", code_vld, code);
                end
            end
            if (e == 36) begin
                vectors++; if (busy !== 1'b0 || code_vld !== 1'b1) begin
                    miscompares++; $display("FAIL ignored_start: got busy=%b vld=%b expected busy=0 vld=1", busy, code_vld);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tie = -1; thr = 19;
        pulse_start();
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (code !== 5'd16 || busy !== 1'b0 || code_vld !== 1'b0) begin
            miscompares++; $display("FAIL async_reset: got code=%0d busy=%b vld=%b expected 16/0/0", code, busy, code_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        repeat (26) @(posedge clk);
        #1;
        vectors++; if (code !== 5'd18 || code_vld !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_cal: got code=%0d vld=%b busy=%b expected 18/1/0", code, code_vld, busy);
        end
    endtask

    task automatic test_back_to_back();
        tie = -1; thr = 19;
        pulse_start();
        @(posedge clk); #1;
        vectors++; if (code !== 5'd16 || busy !== 1'b1 || code_vld !== 1'b0) begin
            miscompares++; $display("FAIL restart: got code=%0d busy=%b vld=%b expected 16/1/0", code, busy, code_vld);
        end
        repeat (25) @(posedge clk);
        #1;
        vectors++; if (code !== 5'd18 || code_vld !== 1'b1) begin
            miscompares++; $display("FAIL restart_lock: got code=%0d vld=%b expected 18/1", code, code_vld);
        end
    endtask

    task automatic test_lock_hold();
        thr = 21;
        for (int k = 0; k < 6; k++) begin
            repeat (20) @(posedge clk);
            #1;
            vectors++; if (code !== 5'd18 || code_vld !== 1'b1) begin
                miscompares++; $display("FAIL lock_hold%0d: got code=%0d vld=%b expected 18/1", k, code, code_vld);
            end
        end
        thr = 19;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; freeze = 1'b0;
        test_reset();
        test_nominal();
        test_saturation();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        test_lock_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
